relu_act_pipe: RTL and testbench

//  Multi-lane, pipelined activation unit. Successor to the single-lane 8-bit ReLU.

---
 rtl/relu_act_pkg.sv | 23 ++
 rtl/relu_lane.sv | 49 ++++
 rtl/relu_act_pipe.sv | 126 ++++++++++++
 tb/tb_relu_act_pipe.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/relu_act_pkg.sv
// Shared constants and helpers for the multi-lane activation pipeline.
package relu_act_pkg;

    localparam logic [1:0] ACT_BYPASS = 2'b00;
    localparam logic [1:0] ACT_RELU   = 2'b01;
    localparam logic [1:0] ACT_LEAKY  = 2'b10;
    localparam logic [1:0] ACT_CLAMP  = 2'b11;

    localparam int MAX_LANES = 64;
    localparam int POP_W     = 8;

    function automatic logic [POP_W-1:0] popcount(
        input logic [MAX_LANES-1:0] flags
    );
        logic [POP_W-1:0] n;
        n = '0;
        for (int i = 0; i < MAX_LANES; i++) begin
            n = n + {{(POP_W-1){1'b0}}, flags[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/relu_lane.sv
// One activation lane: combinational bypass / ReLU / leaky / clamp on a
// signed element, plus a flag that is set when the output differs from x.
module relu_lane
    import relu_act_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int LEAK_SHIFT = 3
) (
    input  logic signed [DATA_W-1:0] x,
    input  logic        [1:0]        mode,
    input  logic signed [DATA_W-1:0] cap,
    output logic signed [DATA_W-1:0] y,
    output logic                     clipped
);

    logic neg;
    logic cap_neg;

    assign neg     = x[DATA_W-1];
    assign cap_neg = cap[DATA_W-1];

    always_comb begin
        y = x;
        unique case (1'b1)
            (mode == ACT_RELU): begin
                y = neg ? '0 : x;
            end
            (mode == ACT_LEAKY): begin
                y = neg ? (x >>> LEAK_SHIFT) : x;
            end
            (mode == ACT_CLAMP): begin
                // A negative ceiling forces every lane to zero.
                if (neg || cap_neg) begin
                    y = '0;
                end else if (x > cap) begin
                    y = cap;
                end else begin
                    y = x;
                end
            end
            default: begin
                y = x;
            end
        endcase
    end

    assign clipped = (y != x);

endmodule

// File: rtl/relu_act_pipe.sv
// Two-stage valid/ready activation pipeline over LANES signed elements,
// with a saturating count of lanes altered by the activation.
module relu_act_pipe
    import relu_act_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int LANES      = 4,
    parameter int LEAK_SHIFT = 3,
    parameter int CNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [1:0]              mode,
    input  logic [DATA_W-1:0]       cap,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*DATA_W-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*DATA_W-1:0] out_data,
    input  logic                    clip_clr,
    output logic [CNT_W-1:0]        clip_cnt
);

    localparam int DW    = LANES * DATA_W;
    localparam int PC_W  = $clog2(LANES + 1);
    localparam int BIG_W = (CNT_W > PC_W) ? CNT_W : PC_W;
    localparam int SUM_W = BIG_W + 1;

    logic              s1_valid;
    logic [DW-1:0]     s1_data;
    logic [1:0]        s1_mode;
    logic [DATA_W-1:0] s1_cap;

    logic              s2_valid;
    logic [DW-1:0]     s2_data;
    logic [PC_W-1:0]   s2_clip;

    logic              s1_ready;
    logic              s2_ready;
    logic              in_fire;
    logic              out_fire;

    logic [DW-1:0]        y_bus;
    logic [LANES-1:0]     clip_flags;
    logic [MAX_LANES-1:0] flags_ext;
    logic [POP_W-1:0]     pop_full;
    logic [PC_W-1:0]      beat_clips;
    logic [SUM_W-1:0]     cnt_sum;

    assign s2_ready = !s2_valid || out_ready;
    assign s1_ready = !s1_valid || s2_ready;
    // Held low during reset so nothing is accepted into a flushing pipe.
    assign in_ready = rst_n && s1_ready;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = s2_valid && out_ready;

    assign out_valid = s2_valid;
    assign out_data  = s2_data;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        relu_lane #(
            .DATA_W     (DATA_W),
            .LEAK_SHIFT (LEAK_SHIFT)
        ) u_lane (
            .x       (s1_data[k*DATA_W +: DATA_W]),
            .mode    (s1_mode),
            .cap     (s1_cap),
            .y       (y_bus[k*DATA_W +: DATA_W]),
            .clipped (clip_flags[k])
        );
    end

    assign flags_ext  = MAX_LANES'(clip_flags);
    assign pop_full   = popcount(flags_ext);
    assign beat_clips = pop_full[PC_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_mode  <= ACT_BYPASS;
            s1_cap   <= '0;
        end else begin
            if (s1_ready) begin
                s1_valid <= in_valid;
            end
            if (in_fire) begin
                s1_data <= in_data;
                s1_mode <= mode;
                s1_cap  <= cap;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_clip  <= '0;
        end else if (s2_ready) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_data <= y_bus;
                s2_clip <= beat_clips;
            end
        end
    end

    assign cnt_sum = SUM_W'(clip_cnt) + SUM_W'(s2_clip);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clip_cnt <= '0;
        end else if (clip_clr) begin
            clip_cnt <= '0;
        end else if (out_fire) begin
            if (|cnt_sum[SUM_W-1:CNT_W]) begin
                clip_cnt <= '1;
            end else begin
                clip_cnt <= cnt_sum[CNT_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_relu_act_pipe.sv
// Scoreboard bench for relu_act_pipe: directed cases, backpressure,
// saturation (second instance with a 3-bit counter), async reset, random.
module tb_relu_act_pipe;

    localparam int DATA_W     = 8;
    localparam int LANES      = 4;
    localparam int LEAK_SHIFT = 3;
    localparam int CNT_W      = 16;
    localparam int SAT_W      = 3;
    localparam int DW         = LANES * DATA_W;
    localparam longint BIG_MAX = 65535;
    localparam longint SAT_MAX = 7;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic [7:0]    cap = 8'd0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          out_ready = 1'b0;
    logic          clip_clr = 1'b0;

    logic             in_ready;
    logic             out_valid;
    logic [DW-1:0]    out_data;
    logic [CNT_W-1:0] clip_cnt;

    logic             sat_in_ready;
    logic             sat_out_valid;
    logic [DW-1:0]    sat_out_data;
    logic [SAT_W-1:0] sat_clip_cnt;

    relu_act_pipe #(
        .DATA_W(DATA_W), .LANES(LANES), .LEAK_SHIFT(LEAK_SHIFT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .cap(cap),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .clip_clr(clip_clr), .clip_cnt(clip_cnt)
    );

    relu_act_pipe #(
        .DATA_W(DATA_W), .LANES(LANES), .LEAK_SHIFT(LEAK_SHIFT), .CNT_W(SAT_W)
    ) dut_sat (
        .clk(clk), .rst_n(rst_n), .mode(mode), .cap(cap),
        .in_valid(in_valid), .in_ready(sat_in_ready), .in_data(in_data),
        .out_valid(sat_out_valid), .out_ready(out_ready), .out_data(sat_out_data),
        .clip_clr(clip_clr), .clip_cnt(sat_clip_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        int            clips;
        longint        acc;
    } exp_t;

    exp_t   exp_q[$];
    int     checks = 0;
    int     failures = 0;
    longint cyc = 0;
    longint clip_model = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input longint got, input longint want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic bound_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
    endtask

    // Reference activation on plain integers.
    function automatic int act(input int x, input int m, input int c);
        int d;
        int r;
        d = 1 << LEAK_SHIFT;
        r = ((x % d) + d) % d;
        case (m)
            1: return (x < 0) ? 0 : x;
            2: return (x < 0) ? (x - r) / d : x;
            3: return (x < 0 || c < 0) ? 0 : ((x > c) ? c : x);
            default: return x;
        endcase
    endfunction

    function automatic exp_t predict(input logic [DW-1:0] d, input logic [1:0] m,
                                     input logic [7:0] c, input longint acc);
        exp_t e;
        int x;
        int y;
        int cs;
        logic [7:0] b;
        e.data  = '0;
        e.clips = 0;
        e.acc   = acc;
        cs = int'($signed(c));
        for (int k = 0; k < LANES; k++) begin
            b = d[k*8 +: 8];
            x = int'($signed(b));
            y = act(x, int'(m), cs);
            e.data[k*8 +: 8] = y[7:0];
            if (y != x) e.clips++;
        end
        return e;
    endfunction

    // Monitor: compares against the scoreboard on every falling edge.
    always @(negedge clk) begin
        logic ev;
        logic hs;
        int   hc;
        hs = 1'b0;
        hc = 0;
        if (!rst_n) begin
            exp_q.delete();
            clip_model = 0;
            chk("rst_out_valid", out_valid, 0);
            chk("rst_in_ready", in_ready, 0);
            chk("rst_out_data", out_data, 0);
            chk("rst_clip_cnt", clip_cnt, 0);
        end else begin
            ev = (exp_q.size() > 0) && (cyc > exp_q[0].acc);
            chk("out_valid", out_valid, ev);
            chk("sat_out_valid", sat_out_valid, ev);
            chk("in_ready", in_ready, (exp_q.size() < 2) || out_ready);
            chk("sat_in_ready", sat_in_ready, (exp_q.size() < 2) || out_ready);
            chk("clip_cnt", clip_cnt, (clip_model > BIG_MAX) ? BIG_MAX : clip_model);
            chk("sat_clip_cnt", sat_clip_cnt, (clip_model > SAT_MAX) ? SAT_MAX : clip_model);
            if (out_valid && exp_q.size() > 0) begin
                chk("out_data", out_data, exp_q[0].data);
                chk("sat_out_data", sat_out_data, exp_q[0].data);
                if (out_ready) begin
                    hs = 1'b1;
                    hc = exp_q[0].clips;
                    void'(exp_q.pop_front());
                end
            end
            if (clip_clr) clip_model = 0;
            else if (hs) clip_model += hc;
        end
    end

    // One cycle of stimulus, called just after a rising edge.
    task automatic step(input logic v, input logic [DW-1:0] d, input logic [1:0] m,
                        input logic [7:0] c, input logic ordy, input logic clr,
                        output logic acc);
        in_valid  = v;
        in_data   = d;
        mode      = m;
        cap       = c;
        out_ready = ordy;
        clip_clr  = clr;
        @(negedge clk);
        acc = v && in_ready;
        @(posedge clk);
        #1;
        if (acc) exp_q.push_back(predict(d, m, c, cyc));
    endtask

    task automatic idle(input logic ordy, input logic clr);
        logic a;
        step(1'b0, '0, 2'b00, 8'd0, ordy, clr, a);
    endtask

    task automatic send(input logic [DW-1:0] d, input logic [1:0] m, input logic [7:0] c);
        logic a;
        a = 1'b0;
        for (int i = 0; i < 50 && !a; i++) step(1'b1, d, m, c, 1'b1, 1'b0, a);
        if (!a) bound_fail("send");
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && exp_q.size() > 0; i++) idle(1'b1, 1'b0);
        if (exp_q.size() > 0) bound_fail("drain");
        idle(1'b1, 1'b0);
    endtask

    localparam logic [DW-1:0] NEG4 = {8'h81, 8'hFF, 8'hF0, 8'h80};

    initial begin
        logic a;
        logic [3:0] pat;
        int n;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1'b1, 1'b0);

        send({8'hAB, 8'd100, 8'd25, 8'd0}, 2'b01, 8'd0);
        send({8'h7F, 8'h80, 8'hFF, 8'hAB}, 2'b10, 8'd0);
        send({8'd50, 8'd100, 8'hFB, 8'd120}, 2'b11, 8'd100);
        send({8'd50, 8'd100, 8'hFB, 8'd120}, 2'b11, 8'hFD);
        drain();

        pat = 4'b1001;
        n = 0;
        for (int i = 0; i < 100 && n < 8; i++) begin
            step(1'b1, $urandom, 2'($urandom_range(0, 3)), 8'($urandom),
                 pat[i % 4], 1'b0, a);
            if (a) n++;
        end
        if (n < 8) bound_fail("backpressure");
        drain();

        idle(1'b1, 1'b1);
        repeat (3) send(NEG4, 2'b01, 8'd0);
        drain();
        step(1'b1, NEG4, 2'b01, 8'd0, 1'b0, 1'b0, a);
        idle(1'b0, 1'b0);
        idle(1'b0, 1'b0);
        idle(1'b1, 1'b1);
        drain();

        step(1'b1, $urandom, 2'b01, 8'd0, 1'b0, 1'b0, a);
        step(1'b1, $urandom, 2'b10, 8'd0, 1'b0, 1'b0, a);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_ready", in_ready, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        send({8'hAB, 8'd3, 8'h90, 8'd77}, 2'b01, 8'd0);
        drain();

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, $urandom, 2'($urandom_range(0, 3)),
                 8'($urandom), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 15) == 0, a);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
